// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, drives the
// datapath enables and mux selects, and stalls on the memory handshake.
module multicycle_ctrl #(
  parameter int OP_W = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            adr_src,
  output logic            mem_write,
  output logic            ir_write,
  output logic [1:0]      result_src,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      imm_src,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic            illegal,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;

  state_t r_state;
  state_t w_next;

  // Enables before reset gating; the gated versions drive the ports.
  logic w_pc_write;
  logic w_mem_write;
  logic w_ir_write;
  logic w_reg_write;

  // State register: the only sequential element in the controller.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state logic and Moore outputs (pc_write/ir_write/next gated by
  // mem_ready or zero where the datapath needs it).
  // NOTE: every output gets a default first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = r_state;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target from OldPC + immediate.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (op == OP_LW || op == OP_SW) w_next = S_MEMADR;
        else if (op == OP_R)            w_next = S_EXECR;
        else if (op == OP_I)            w_next = S_EXECI;
        else if (op == OP_JAL)          w_next = S_JAL;
        else if (op == OP_BEQ)          w_next = S_BEQ;
        else                            w_next = S_ILLEGAL;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe stays high for the whole wait so memory sees a stable request.
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        // PC <= target from DECODE (ALUOut); ALU computes OldPC+4 for rd.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        w_pc_write = zero;
        w_next     = S_FETCH;
      end
      S_ILLEGAL: begin
        // Trap: sit here with every enable off until reset.
        illegal = 1'b1;
        w_next  = S_ILLEGAL;
      end
      default: begin
        // Unused encodings recover to FETCH.
        w_next = S_FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 2'b00;
    if (op == OP_SW)       imm_src = 2'b01;
    else if (op == OP_BEQ) imm_src = 2'b10;
    else if (op == OP_JAL) imm_src = 2'b11;
  end

  // Write enables are masked by reset so an abort can never leak a write.
  assign pc_write  = w_pc_write  & reset_n;
  assign mem_write = w_mem_write & reset_n;
  assign ir_write  = w_ir_write  & reset_n;
  assign reg_write = w_reg_write & reset_n;
  assign state_o   = r_state;

endmodule
